// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bus between a parallel word source and the serializer.
// The serializer takes the slave side; the word source (or bench) takes the master side.
interface seq_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             frame_done;

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output x,
        output x_valid,
        output frame_done
    );

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  x,
        input  x_valid,
        input  frame_done
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the 111 sequence detector: one WIDTH-bit word in,
// one bit per clock out, back-to-back words with no idle gap, line held at 0 while idle.
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seq_serializer_if.slave   bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             frame_done_q, frame_done_d;

    logic             last_bit;
    logic             accept;

    // Ready depends only on state, so there is no din_valid -> din_ready path.
    assign last_bit      = (state_q == SHIFT) && (cnt_q == LAST);
    assign bus.din_ready = (state_q == IDLE) || last_bit;
    assign accept        = bus.din_valid && bus.din_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;

        if (accept) begin
            // First bit goes straight to x; the register keeps the rest pre-shifted.
            state_d   = SHIFT;
            cnt_d     = '0;
            x_valid_d = 1'b1;
            if (MSB_FIRST) begin
                x_d    = bus.din[WIDTH-1];
                sreg_d = bus.din << 1;
            end else begin
                x_d    = bus.din[0];
                sreg_d = bus.din >> 1;
            end
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d   = IDLE;
                cnt_d     = '0;
                sreg_d    = '0;
                x_d       = 1'b0;
                x_valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (MSB_FIRST) begin
                    x_d    = sreg_q[WIDTH-1];
                    sreg_d = sreg_q << 1;
                end else begin
                    x_d    = sreg_q[0];
                    sreg_d = sreg_q >> 1;
                end
            end
        end

        frame_done_d = x_valid_d && (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            x_q          <= 1'b0;
            x_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.x_valid    = x_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an MSB-first and an LSB-first instance share directed stimulus
// and are checked every cycle against a bit-queue model, plus literal per-test expectations.
module tb_seq_serializer;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;

    seq_serializer_if #(.WIDTH(W)) ifm ();
    seq_serializer_if #(.WIDTH(W)) ifl ();

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (ifm.slave)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (ifl.slave)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of bits still to appear on x, head is the bit currently on x.
    bit qm[$];
    bit ql[$];
    logic model_acc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            qm.delete();
            ql.delete();
        end else begin
            model_acc = ifm.din_valid && (qm.size() <= 1);
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (model_acc) begin
                for (int i = 0; i < int'(W); i++) begin
                    qm.push_back(ifm.din[W-1-i]);
                    ql.push_back(ifl.din[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_x_valid",    32'(ifm.x_valid),    32'(qm.size() > 0));
        chk("m_x",          32'(ifm.x),          32'((qm.size() > 0) ? qm[0] : 1'b0));
        chk("m_frame_done", 32'(ifm.frame_done), 32'(qm.size() == 1));
        chk("m_din_ready",  32'(ifm.din_ready),  32'(qm.size() <= 1));
        chk("l_x_valid",    32'(ifl.x_valid),    32'(ql.size() > 0));
        chk("l_x",          32'(ifl.x),          32'((ql.size() > 0) ? ql[0] : 1'b0));
        chk("l_frame_done", 32'(ifl.frame_done), 32'(ql.size() == 1));
        chk("l_din_ready",  32'(ifl.din_ready),  32'(ql.size() <= 1));
    end

    task automatic set_in(input logic v, input logic [W-1:0] d);
        ifm.din       = d;
        ifm.din_valid = v;
        ifl.din       = d;
        ifl.din_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_m_x"},  32'(ifm.x),          32'(0));
        chk({nm, "_m_xv"}, 32'(ifm.x_valid),    32'(0));
        chk({nm, "_m_fd"}, 32'(ifm.frame_done), 32'(0));
        chk({nm, "_m_rdy"},32'(ifm.din_ready),  32'(1));
        chk({nm, "_l_x"},  32'(ifl.x),          32'(0));
        chk({nm, "_l_xv"}, 32'(ifl.x_valid),    32'(0));
    endtask

    logic [15:0] gm, gl, gv, gr, gf;

    // Capture n bits from both instances, MSB of the capture = first bit in time.
    task automatic capture8();
        gm = '0; gl = '0; gf = '0;
        for (int i = 0; i < 8; i++) begin
            gm[7-i] = ifm.x;
            gl[7-i] = ifl.x;
            gf[7-i] = ifm.frame_done;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b1, 8'h5A);
        #2 rst = 1'b0;
        #1 chk_idle("reset_async");
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 8'h5A ^ 8'(i));
            step();
            chk_idle("reset_hold");
        end
        set_in(1'b0, 8'h00);
        rst = 1'b1;
        step();
        step();
        chk_idle("idle");

        // Single word, 1110_0111
        set_in(1'b1, 8'hE7);
        step();
        set_in(1'b0, 8'h00);
        capture8();
        chk("single_m_bits", 32'(gm), 32'h00E7);
        chk("single_l_bits", 32'(gl), 32'h00E7);
        chk("single_fd",     32'(gf), 32'h0001);
        chk_idle("single_after");

        // Back-to-back FF then 00 with valid held through the hand-over
        set_in(1'b1, 8'hFF);
        step();
        gm = '0; gl = '0; gv = '0; gr = '0; gf = '0;
        for (int i = 0; i < 16; i++) begin
            gm[15-i] = ifm.x;
            gl[15-i] = ifl.x;
            gv[15-i] = ifm.x_valid;
            gr[15-i] = ifm.din_ready;
            gf[15-i] = ifm.frame_done;
            set_in(i <= 7, 8'h00);
            step();
        end
        chk("b2b_m_bits", 32'(gm), 32'hFF00);
        chk("b2b_l_bits", 32'(gl), 32'hFF00);
        chk("b2b_valid",  32'(gv), 32'hFFFF);
        chk("b2b_ready",  32'(gr), 32'h0101);
        chk("b2b_fd",     32'(gf), 32'h0101);
        chk_idle("b2b_after");

        // Bit order: 0000_0111
        set_in(1'b1, 8'h07);
        step();
        set_in(1'b0, 8'h00);
        capture8();
        chk("order_l_bits", 32'(gl), 32'h00E0);
        chk("order_m_bits", 32'(gm), 32'h0007);

        // din changes during a word are ignored
        set_in(1'b1, 8'hFF);
        step();
        set_in(1'b0, 8'h00);
        capture8();
        chk("stable_m_bits", 32'(gm), 32'h00FF);
        chk("stable_l_bits", 32'(gl), 32'h00FF);
        for (int i = 0; i < 3; i++) begin
            chk_idle("stable_idle");
            set_in(1'b0, 8'hFF);
            step();
        end

        // Reset three bits into a word of 1s
        set_in(1'b1, 8'hFF);
        step();
        set_in(1'b0, 8'hFF);
        step();
        step();
        chk("midrst_pre_xv", 32'(ifm.x_valid), 32'(1));
        chk("midrst_pre_x",  32'(ifm.x),       32'(1));
        #2 rst = 1'b0;
        #1 chk_idle("midrst");
        step();
        rst = 1'b1;
        step();
        chk_idle("midrst_release");

        set_in(1'b1, 8'hA5);
        step();
        set_in(1'b0, 8'h00);
        capture8();
        chk("a5_m_bits", 32'(gm), 32'h00A5);
        chk("a5_l_bits", 32'(gl), 32'h00A5);
        chk("a5_fd",     32'(gf), 32'h0001);
        chk_idle("a5_after");
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
